// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters,
// with an optional bounded lock for exclusive back-to-back (read-modify-write) access.
module ram_port_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic [ADDR_W-1:0]         ram_address,
    output logic [DATA_W-1:0]         ram_wr_data,
    output logic                      ram_we,
    input  logic [DATA_W-1:0]         ram_rd_data
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   prio_reg, prio_next;
    logic [CNT_W-1:0]   lock_cnt_reg, lock_cnt_next;
    logic [NUM_REQ-1:0] resp_valid_reg;
    logic [DATA_W-1:0]  rdata_hold_reg;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic               timeout;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign timeout = (state_reg == LOCKED) && (lock_cnt_reg == CNT_W'(LOCK_MAX - 1));

    // Winner selection; nothing is granted while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (rst_n) begin
            if (state_reg == LOCKED) begin
                if (req_valid[owner_reg]) begin
                    grant_any = 1'b1;
                    grant_idx = owner_reg;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!grant_any && req_valid[(int'(prio_reg) + k) % NUM_REQ]) begin
                        grant_any = 1'b1;
                        grant_idx = IDX_W'((int'(prio_reg) + k) % NUM_REQ);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= UNLOCKED;
            owner_reg      <= '0;
            prio_reg       <= '0;
            lock_cnt_reg   <= '0;
            resp_valid_reg <= '0;
            rdata_hold_reg <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            prio_reg       <= prio_next;
            lock_cnt_reg   <= lock_cnt_next;
            resp_valid_reg <= req_ready;
            if (|resp_valid_reg) begin
                rdata_hold_reg <= ram_rd_data;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        prio_next     = prio_reg;
        lock_cnt_next = lock_cnt_reg;
        if (grant_any) begin
            prio_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
        case (state_reg)
            UNLOCKED: begin
                if (grant_any && req_lock[grant_idx]) begin
                    state_next    = LOCKED;
                    owner_next    = grant_idx;
                    lock_cnt_next = '0;
                end
            end
            LOCKED: begin
                lock_cnt_next = lock_cnt_reg + CNT_W'(1);
                // Timeout wins over the owner's lock bit at the same edge.
                if (timeout || (grant_any && !req_lock[owner_reg])) begin
                    state_next    = UNLOCKED;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = UNLOCKED;
                lock_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        req_ready   = '0;
        ram_address = '0;
        ram_wr_data = '0;
        ram_we      = 1'b0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            ram_address          = addr_arr[grant_idx];
            ram_wr_data          = wdata_arr[grant_idx];
            ram_we               = req_we[grant_idx];
        end
    end

    // The RAM output is already registered, so it is forwarded directly in the response cycle.
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = (|resp_valid_reg) ? ram_rd_data : rdata_hold_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level model of arbitration, locking and RAM contents.
module tb_ram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LM = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_we = '0, req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, resp_valid;
    logic [DW-1:0]   resp_rdata, ram_wr_data, ram_rd_data;
    logic [AW-1:0]   ram_address;
    logic            ram_we;

    logic            pre_we = 1'b0;
    logic [AW-1:0]   pre_addr = '0;
    logic [DW-1:0]   pre_data = '0;
    logic [DW-1:0]   mem [256];
    logic [DW-1:0]   model_mem [256];

    int checks = 0;
    int failures = 0;

    ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ram_address(ram_address), .ram_wr_data(ram_wr_data), .ram_we(ram_we),
        .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Write-first RAM with registered read; pre_* loads contents while the arbiter is idle.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_address] <= ram_wr_data;
            ram_rd_data      <= ram_wr_data;
        end else begin
            if (pre_we) mem[pre_addr] <= pre_data;
            ram_rd_data <= mem[ram_address];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_lock[i]           = lk;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = (i == 5) ? 16'h00A5 : DW'((i * 16'h0101) ^ 16'h5A3C);
            model_mem[i] = v;
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = v;
            step();
        end
        pre_we = 1'b0;
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        checks++;
        if (resp_valid !== '0) begin failures++; $display("FAIL reset_resp_valid: got %b want 000", resp_valid); end
        checks++;
        if (resp_rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        checks++;
        if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        $display("reset: ready=%b resp_valid=%b rdata=%h", req_ready, resp_valid, resp_rdata);
        clear_all();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        set_req(0, 1, 0, 0, 8'd5, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001 || ram_address !== 8'd5 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL single_read_grant: ready=%b addr=%h we=%b want 001/05/0", req_ready, ram_address, ram_we);
        end
        step();
        clear_all();
        @(negedge clk);
        checks++;
        if (resp_valid !== 3'b001 || resp_rdata !== 16'h00A5) begin
            failures++;
            $display("FAIL single_read_resp: valid=%b rdata=%h want 001/00a5", resp_valid, resp_rdata);
        end
        $display("single_read: addr 5 -> resp_valid=%b rdata=%h", resp_valid, resp_rdata);
        step();
    endtask

    task automatic test_write_then_read();
        set_req(1, 1, 1, 0, 8'd9, 16'h1234);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010 || ram_we !== 1'b1 || ram_address !== 8'd9 || ram_wr_data !== 16'h1234) begin
            failures++;
            $display("FAIL write_grant: ready=%b we=%b addr=%h wd=%h want 010/1/09/1234", req_ready, ram_we, ram_address, ram_wr_data);
        end
        step();
        model_mem[9] = 16'h1234;
        set_req(1, 1, 0, 0, 8'd9, '0);
        @(negedge clk);
        checks++;
        if (resp_valid !== 3'b010 || resp_rdata !== 16'h1234 || req_ready !== 3'b010) begin
            failures++;
            $display("FAIL write_resp: valid=%b rdata=%h ready=%b want 010/1234/010", resp_valid, resp_rdata, req_ready);
        end
        step();
        clear_all();
        @(negedge clk);
        checks++;
        if (resp_valid !== 3'b010 || resp_rdata !== 16'h1234) begin
            failures++;
            $display("FAIL read_after_write: valid=%b rdata=%h want 010/1234", resp_valid, resp_rdata);
        end
        checks++;
        if (mem[9] !== 16'h1234) begin failures++; $display("FAIL ram_contents: mem[9]=%h want 1234", mem[9]); end
        $display("write_then_read: mem[9]=%h rdata=%h", mem[9], resp_rdata);
        step();
    endtask

    task automatic test_fairness();
        int exp_g;
        do_reset();
        set_req(0, 1, 0, 0, 8'h10, '0);
        set_req(1, 1, 0, 0, 8'h20, '0);
        for (int c = 0; c < 8; c++) begin
            exp_g = c % 2;
            @(negedge clk);
            checks++;
            if (req_ready !== 3'(1 << exp_g)) begin
                failures++;
                $display("FAIL fairness_grant cyc %0d: ready=%b want %b", c, req_ready, 3'(1 << exp_g));
            end
            if (c > 0) begin
                checks++;
                if (resp_valid !== 3'(1 << (1 - exp_g)) || resp_rdata !== model_mem[(1 - exp_g) ? 8'h20 : 8'h10]) begin
                    failures++;
                    $display("FAIL fairness_resp cyc %0d: valid=%b rdata=%h", c, resp_valid, resp_rdata);
                end
            end
            $display("fairness cyc %0d: ready=%b resp_valid=%b", c, req_ready, resp_valid);
            step();
        end
        clear_all();
        @(negedge clk);
        checks++;
        if (resp_valid !== 3'b010) begin failures++; $display("FAIL fairness_last_resp: valid=%b want 010", resp_valid); end
        step();
    endtask

    task automatic test_lock();
        logic [2:0] lk_seq;
        lk_seq = 3'b011;
        do_reset();
        set_req(1, 1, 0, 0, 8'h30, '0);
        for (int c = 0; c < 3; c++) begin
            set_req(0, 1, 0, lk_seq[c], AW'(8'h40 + c), '0);
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b001) begin
                failures++;
                $display("FAIL lock_owner cyc %0d: ready=%b want 001", c, req_ready);
            end
            $display("lock cyc %0d: lock=%b ready=%b", c, lk_seq[c], req_ready);
            step();
        end
        set_req(0, 0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010 || resp_valid !== 3'b001) begin
            failures++;
            $display("FAIL lock_release: ready=%b resp_valid=%b want 010/001", req_ready, resp_valid);
        end
        step();
        clear_all();
    endtask

    task automatic test_lock_timeout();
        do_reset();
        set_req(1, 1, 0, 0, 8'h31, '0);
        set_req(0, 1, 0, 1, 8'h32, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin failures++; $display("FAIL timeout_lock_grant: ready=%b want 001", req_ready); end
        step();
        set_req(0, 0, 0, 0, '0, '0);
        for (int k = 0; k < LM; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b000) begin
                failures++;
                $display("FAIL timeout_held cyc %0d: ready=%b want 000", k, req_ready);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin failures++; $display("FAIL timeout_release: ready=%b want 010", req_ready); end
        $display("lock_timeout: after %0d locked cycles ready=%b", LM, req_ready);
        step();
        clear_all();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_req(0, 1, 0, 1, 8'd5, '0);
        set_req(1, 1, 0, 0, 8'd6, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin failures++; $display("FAIL arst_grant: ready=%b want 001", req_ready); end
        step();
        rst_n = 1'b0;
        set_req(0, 1, 0, 0, 8'd5, '0);
        #1;
        checks++;
        if (resp_valid !== 3'b000) begin failures++; $display("FAIL arst_resp_drop: valid=%b want 000", resp_valid); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 3'b000 || req_ready !== 3'b000) begin
                failures++;
                $display("FAIL arst_held cyc %0d: valid=%b ready=%b want 000/000", k, resp_valid, req_ready);
            end
            step();
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin failures++; $display("FAIL arst_first_grant: ready=%b want 001", req_ready); end
        step();
        set_req(0, 0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010 || resp_valid !== 3'b001) begin
            failures++;
            $display("FAIL arst_lock_cleared: ready=%b valid=%b want 010/001", req_ready, resp_valid);
        end
        $display("async_reset: post-reset ready=%b resp_valid=%b", req_ready, resp_valid);
        step();
        clear_all();
    endtask

    task automatic test_random();
        int            m_prio, m_owner, m_held, g, prev_g;
        bit            m_locked;
        logic [DW-1:0] exp_rdata, last_rdata;
        logic [N-1:0]  v, we, lk, exp_rdy;
        logic [AW-1:0] a [N];
        logic [DW-1:0] d [N];
        do_reset();
        m_prio = 0; m_owner = 0; m_held = 0; m_locked = 0;
        prev_g = -1; exp_rdata = '0; last_rdata = '0;
        v = '0; we = '0; lk = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i]) begin
                    v[i]  = ($urandom_range(0, 9) < 6);
                    we[i] = 1'($urandom_range(0, 1));
                    lk[i] = ($urandom_range(0, 9) < 3);
                    a[i]  = AW'($urandom_range(0, 15));
                    d[i]  = DW'($urandom);
                end
                set_req(i, v[i], we[i], lk[i], a[i], d[i]);
            end
            g = -1;
            if (m_locked) begin
                if (v[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N && g < 0; k++) begin
                    if (v[(m_prio + k) % N]) g = (m_prio + k) % N;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rand_grant cyc %0d: ready=%b want %b", cyc, req_ready, exp_rdy);
            end
            checks++;
            if (g >= 0) begin
                if (ram_address !== a[g] || ram_we !== we[g] || ram_wr_data !== d[g]) begin
                    failures++;
                    $display("FAIL rand_ram cyc %0d: addr=%h we=%b wd=%h want %h/%b/%h", cyc, ram_address, ram_we, ram_wr_data, a[g], we[g], d[g]);
                end
            end else if (ram_we !== 1'b0 || ram_address !== '0 || ram_wr_data !== '0) begin
                failures++;
                $display("FAIL rand_ram_idle cyc %0d: addr=%h we=%b wd=%h want zeros", cyc, ram_address, ram_we, ram_wr_data);
            end
            checks++;
            if (prev_g >= 0) begin
                if (resp_valid !== 3'(1 << prev_g) || resp_rdata !== exp_rdata) begin
                    failures++;
                    $display("FAIL rand_resp cyc %0d: valid=%b rdata=%h want %b/%h", cyc, resp_valid, resp_rdata, 3'(1 << prev_g), exp_rdata);
                end
                last_rdata = exp_rdata;
            end else if (resp_valid !== 3'b000 || resp_rdata !== last_rdata) begin
                failures++;
                $display("FAIL rand_resp_idle cyc %0d: valid=%b rdata=%h want 000/%h", cyc, resp_valid, resp_rdata, last_rdata);
            end
            $display("rand cyc %0d: valid=%b grant=%0d locked=%0d resp_valid=%b rdata=%h", cyc, v, g, m_locked, resp_valid, resp_rdata);
            if (g >= 0) begin
                if (we[g]) model_mem[a[g]] = d[g];
                exp_rdata = model_mem[a[g]];
                m_prio = (g + 1) % N;
            end
            if (m_locked) begin
                m_held++;
                if (m_held == LM || (g >= 0 && !lk[g])) m_locked = 0;
            end else if (g >= 0 && lk[g]) begin
                m_locked = 1;
                m_owner  = g;
                m_held   = 0;
            end
            if (g >= 0) v[g] = 1'b0;
            prev_g = g;
            step();
        end
        clear_all();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_fairness();
        test_lock();
        test_lock_timeout();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
